chirp_sequencer: RTL and testbench
==================================

# chirp_sequencer

Control stage in the clk_48 domain that feeds dds_chirp. Accepts a chirp parameter set from the host side and transfers it to the DDS with a 4-phase REQ/ACK handshake. Then generates a burst of `start` gates of programmed length, gap and count. It is the sole driver of DDS_freq, DDS_delta_freq, DDS_delta_rate, REQ and start.

## Interface
- FREQ_W, 48, width of frequency words
- RATE_W, 32, width of delta-rate, length and gap fields
- CNT_W, 16, width of pulse count
- clk_48  in  1  system clock, 48 MHz
- rst  in  1  reset: synchronous, active-high
- cfg_wr  in  1  one-cycle strobe; capture cfg_* fields
- cfg_freq  in  FREQ_W  start frequency word
- cfg_delta_freq  in  FREQ_W  frequency step
- cfg_delta_rate  in  RATE_W  clocks per step, passed through
- cfg_len  in  RATE_W  start-high length in clk_48 cycles; 0 treated as 1
- cfg_gap  in  RATE_W  start-low length between pulses; values below 2 treated as 2
- cfg_count  in  CNT_W  pulses per burst; 0 means continuous until abort
- arm  in  1  one-cycle strobe; begin burst
- abort  in  1  one-cycle strobe; stop burst
- ACK  in  1  handshake acknowledge from dds_chirp, already synchronised to clk_48
- REQ  out  1  handshake request
- DDS_freq, DDS_delta_freq  out  FREQ_W  registered parameter outputs
- DDS_delta_rate  out  RATE_W  registered parameter output
- start  out  1  DDS run gate
- ready  out  1  parameters loaded, idle, armable
- busy  out  1  handshake or burst in progress
- done  out  1  one-cycle pulse at end of a finite burst
- cfg_rej  out  1  one-cycle pulse: cfg_wr ignored
- pulse_cnt  out  CNT_W  pulses completed in current burst

## Operation
- States:
  - IDLE: nothing loaded.
  - LOAD_REQ: REQ=1, waiting for ACK=1.
  - LOAD_REL: REQ=0, waiting for ACK=0.
  - READY.
  - RUN: start=1.
  - GAP: start=0, more pulses pending.
- cfg_wr in IDLE or READY: latch all cfg_* fields and apply the len/gap clamps. DDS_* outputs update from the latched fields, then the state goes to LOAD_REQ. READY drops while the load is in progress.
- cfg_wr in any other state: ignored, cfg_rej=1 for one cycle.
- LOAD_REQ exits to LOAD_REL on ACK=1. LOAD_REL exits to READY on ACK=0.
- DDS_* outputs stay constant from REQ rise until the next accepted cfg_wr. They never change while start=1.
- arm in READY: go to RUN and clear pulse_cnt. arm in any other state is ignored.
- RUN lasts exactly len cycles. At the end pulse_cnt increments, then:
  - if cfg_count≠0 and the new pulse_cnt equals cfg_count: done=1 and go to READY, with no trailing gap;
  - otherwise go to GAP for exactly gap cycles, then back to RUN.
- abort in RUN or GAP: start=0 next cycle, go to READY. No done pulse, pulse_cnt holds.
- abort in IDLE, READY, LOAD_REQ or LOAD_REL: ignored. A started handshake always completes.
- Simultaneous events:
  - abort and arm in READY: arm wins.
  - cfg_wr and arm in READY: cfg_wr wins and arm is dropped.
- Length and gap counters are RATE_W wide and compare against the clamped value minus 1. No wrap occurs within a phase.
- pulse_cnt saturates at all-ones in continuous mode.
- busy=1 in LOAD_REQ, LOAD_REL, RUN and GAP.

## Timing
- Reset state:
  - state IDLE;
  - REQ, start, ready, busy, done, cfg_rej = 0;
  - DDS_* = 0;
  - pulse_cnt = 0.
- Reset mid-burst: start=0 on the next cycle. Reset mid-handshake: REQ=0 on the next cycle.
- cfg_wr at cycle t: DDS_* valid and REQ=1 at t+1.
- ACK=1 first sampled at a: REQ=0 at a+1.
- ACK=0 first sampled at b: ready=1 at b+1.
- arm at t: start=1 during t+1 … t+len.
- Gap: start=0 for exactly gap cycles. The minimum of 2 guarantees the rising edge of start is detected across the clk_96 3-flop edge detector.
- done is asserted in the first cycle start=0 after the last pulse, coincident with ready returning to 1.
- All outputs are registered; nothing passes combinationally from input to output.

## Structure
- Package chirp_pkg holds:
  - state enum;
  - FREQ_W, RATE_W, CNT_W;
  - MIN_GAP=2, MIN_LEN=1.
- Sub-module req_ack_src: 4-phase source-side handshake FSM with inputs go and ACK and outputs REQ and xfer_done. It is instantiated once.
- The sequencer FSM and counters live in chirp_sequencer.

## Test plan
- Load: cfg_wr with freq=0x0000_1000_0000, ACK modelled as 4-cycle delayed REQ → REQ high until ACK, ready=1 one cycle after ACK falls, DDS_freq=0x0000_1000_0000.
- Burst: len=5, gap=3, count=3, arm → three start pulses of 5 cycles separated by 3 low cycles; done once; pulse_cnt=3.
- Clamps: len=0, gap=0, count=2 → pulses of 1 cycle with a 2-cycle gap.
- Abort: count=0, len=10, abort in the 7th pulse's 4th high cycle → start=0 next cycle, ready=1, no done, pulse_cnt=6.
- Rejects: cfg_wr during RUN and during LOAD_REQ → cfg_rej pulse, DDS_* unchanged, burst and handshake unaffected.
- Reset: rst asserted while start=1 and separately while REQ=1 → start and REQ fall next cycle, state IDLE, later arm ignored until a new load.

Source files
------------

// File: rtl/chirp_pkg.sv
// Shared types, widths and helpers for the chirp sequencer and its handshake source.
package chirp_pkg;

  localparam int FREQ_W = 48;
  localparam int RATE_W = 32;
  localparam int CNT_W  = 16;

  // Smallest programmable phase lengths, in clk_48 cycles.
  localparam logic [RATE_W-1:0] MIN_GAP = 32'd2;
  localparam logic [RATE_W-1:0] MIN_LEN = 32'd1;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_REQ = 3'd1,
    LOAD_REL = 3'd2,
    READY    = 3'd3,
    RUN      = 3'd4,
    GAP      = 3'd5
  } seq_state_t;

  // Source-side 4-phase handshake states.
  typedef enum logic [1:0] {
    HS_IDLE = 2'd0,
    HS_REQ  = 2'd1,
    HS_REL  = 2'd2
  } hs_state_t;

  // Raise a phase length to its minimum, then return it minus one so the
  // phase counter (which starts at 0) can terminate on an equality compare.
  function automatic logic [RATE_W-1:0] clamp_m1(input logic [RATE_W-1:0] value,
                                                 input logic [RATE_W-1:0] min_value);
    logic [RATE_W-1:0] clamped;
    if (value < min_value) begin
      clamped = min_value;
    end else begin
      clamped = value;
    end
    return clamped - 32'd1;
  endfunction

endpackage

// File: rtl/chirp_sequencer_if.sv
// DDS-side bus: parameter words, run gate and the 4-phase REQ/ACK pair.
interface chirp_sequencer_if;
  import chirp_pkg::*;

  logic              REQ;
  logic              ACK;
  logic [FREQ_W-1:0] DDS_freq;
  logic [FREQ_W-1:0] DDS_delta_freq;
  logic [RATE_W-1:0] DDS_delta_rate;
  logic              start;

  // Sequencer side: drives parameters, REQ and start.
  modport master (
    output REQ,
    output DDS_freq,
    output DDS_delta_freq,
    output DDS_delta_rate,
    output start,
    input  ACK
  );

  // DDS side: consumes parameters and answers with ACK.
  modport slave (
    input  REQ,
    input  DDS_freq,
    input  DDS_delta_freq,
    input  DDS_delta_rate,
    input  start,
    output ACK
  );

endinterface

// File: rtl/chirp_sequencer_req_ack_src.sv
// Source side of a 4-phase REQ/ACK handshake. REQ is registered; xfer_done
// flags the cycle in which the released ACK is seen so the caller can leave
// its load phase on the same edge.
module req_ack_src
  import chirp_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic ACK,
  output logic REQ,
  output logic xfer_done
);

  hs_state_t state_r;
  hs_state_t state_next_s;
  logic      req_r;

  // Next-state decode for the handshake phases.
  always_comb begin
    state_next_s = state_r;
    xfer_done    = 1'b0;
    case (state_r)
      HS_IDLE: begin
        if (go) begin
          state_next_s = HS_REQ;
        end else begin
          state_next_s = HS_IDLE;
        end
      end
      HS_REQ: begin
        if (ACK) begin
          state_next_s = HS_REL;
        end else begin
          state_next_s = HS_REQ;
        end
      end
      HS_REL: begin
        if (!ACK) begin
          state_next_s = HS_IDLE;
          xfer_done    = 1'b1;
        end else begin
          state_next_s = HS_REL;
        end
      end
      default: begin
        state_next_s = HS_IDLE;
      end
    endcase
  end

  // State register and registered REQ, derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= HS_IDLE;
      req_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      req_r   <= (state_next_s == HS_REQ);
    end
  end

  assign REQ = req_r;

endmodule

// File: rtl/chirp_sequencer.sv
// Chirp sequencer: latches a DDS parameter set, hands it over with a 4-phase
// REQ/ACK transfer, then gates the DDS with bursts of start pulses of
// programmed length, gap and count. All outputs are registered.
module chirp_sequencer
  import chirp_pkg::*;
(
  input  logic              clk_48,
  input  logic              rst,
  input  logic              cfg_wr,
  input  logic [FREQ_W-1:0] cfg_freq,
  input  logic [FREQ_W-1:0] cfg_delta_freq,
  input  logic [RATE_W-1:0] cfg_delta_rate,
  input  logic [RATE_W-1:0] cfg_len,
  input  logic [RATE_W-1:0] cfg_gap,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic              arm,
  input  logic              abort,
  chirp_sequencer_if.master bus,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              cfg_rej,
  output logic [CNT_W-1:0]  pulse_cnt
);

  seq_state_t        state_r;
  seq_state_t        state_next_s;

  logic [FREQ_W-1:0] dds_freq_r;
  logic [FREQ_W-1:0] dds_delta_freq_r;
  logic [RATE_W-1:0] dds_delta_rate_r;
  logic [RATE_W-1:0] len_m1_r;
  logic [RATE_W-1:0] gap_m1_r;
  logic [CNT_W-1:0]  count_r;

  logic [RATE_W-1:0] cnt_r;
  logic [RATE_W-1:0] cnt_next_s;
  logic [CNT_W-1:0]  pulse_cnt_r;
  logic [CNT_W-1:0]  pulse_cnt_inc_s;
  logic [CNT_W-1:0]  pulse_cnt_next_s;

  logic              accept_cfg_s;
  logic              reject_cfg_s;
  logic              done_s;

  logic              start_r;
  logic              ready_r;
  logic              busy_r;
  logic              done_r;
  logic              cfg_rej_r;

  logic              req_s;
  logic              xfer_done_s;

  req_ack_src u_req_ack_src (
    .clk       (clk_48),
    .rst       (rst),
    .go        (accept_cfg_s),
    .ACK       (bus.ACK),
    .REQ       (req_s),
    .xfer_done (xfer_done_s)
  );

  // Sequencer next state, event decode and counter next values.
  always_comb begin
    state_next_s     = state_r;
    accept_cfg_s     = 1'b0;
    reject_cfg_s     = 1'b0;
    done_s           = 1'b0;
    pulse_cnt_next_s = pulse_cnt_r;

    // Saturating increment keeps continuous bursts from wrapping the count.
    if (pulse_cnt_r == {CNT_W{1'b1}}) begin
      pulse_cnt_inc_s = pulse_cnt_r;
    end else begin
      pulse_cnt_inc_s = pulse_cnt_r + 16'd1;
    end

    case (state_r)
      IDLE: begin
        if (cfg_wr) begin
          accept_cfg_s = 1'b1;
          state_next_s = LOAD_REQ;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOAD_REQ: begin
        reject_cfg_s = cfg_wr;
        if (bus.ACK) begin
          state_next_s = LOAD_REL;
        end else begin
          state_next_s = LOAD_REQ;
        end
      end
      LOAD_REL: begin
        reject_cfg_s = cfg_wr;
        if (xfer_done_s) begin
          state_next_s = READY;
        end else begin
          state_next_s = LOAD_REL;
        end
      end
      READY: begin
        // A new load takes priority over arming; abort has no effect here.
        if (cfg_wr) begin
          accept_cfg_s = 1'b1;
          state_next_s = LOAD_REQ;
        end else if (arm) begin
          pulse_cnt_next_s = {CNT_W{1'b0}};
          state_next_s     = RUN;
        end else begin
          state_next_s = READY;
        end
      end
      RUN: begin
        reject_cfg_s = cfg_wr;
        if (abort) begin
          state_next_s = READY;
        end else if (cnt_r == len_m1_r) begin
          pulse_cnt_next_s = pulse_cnt_inc_s;
          if ((count_r != 16'd0) && (pulse_cnt_inc_s == count_r)) begin
            done_s       = 1'b1;
            state_next_s = READY;
          end else begin
            state_next_s = GAP;
          end
        end else begin
          state_next_s = RUN;
        end
      end
      GAP: begin
        reject_cfg_s = cfg_wr;
        if (abort) begin
          state_next_s = READY;
        end else if (cnt_r == gap_m1_r) begin
          state_next_s = RUN;
        end else begin
          state_next_s = GAP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase

    // The phase counter restarts on every state change and only counts
    // while a RUN or GAP phase continues.
    if ((state_next_s == state_r) && ((state_r == RUN) || (state_r == GAP))) begin
      cnt_next_s = cnt_r + 32'd1;
    end else begin
      cnt_next_s = 32'd0;
    end
  end

  // State, parameter latches, counters and registered status outputs.
  always_ff @(posedge clk_48) begin
    if (rst) begin
      state_r          <= IDLE;
      dds_freq_r       <= 48'd0;
      dds_delta_freq_r <= 48'd0;
      dds_delta_rate_r <= 32'd0;
      len_m1_r         <= 32'd0;
      gap_m1_r         <= 32'd1;
      count_r          <= 16'd0;
      cnt_r            <= 32'd0;
      pulse_cnt_r      <= 16'd0;
      start_r          <= 1'b0;
      ready_r          <= 1'b0;
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
      cfg_rej_r        <= 1'b0;
    end else begin
      state_r <= state_next_s;
      // Parameters only move on an accepted write, which can never happen
      // while start is high.
      if (accept_cfg_s) begin
        dds_freq_r       <= cfg_freq;
        dds_delta_freq_r <= cfg_delta_freq;
        dds_delta_rate_r <= cfg_delta_rate;
        len_m1_r         <= clamp_m1(cfg_len, MIN_LEN);
        gap_m1_r         <= clamp_m1(cfg_gap, MIN_GAP);
        count_r          <= cfg_count;
      end else begin
        dds_freq_r       <= dds_freq_r;
        dds_delta_freq_r <= dds_delta_freq_r;
        dds_delta_rate_r <= dds_delta_rate_r;
        len_m1_r         <= len_m1_r;
        gap_m1_r         <= gap_m1_r;
        count_r          <= count_r;
      end
      cnt_r       <= cnt_next_s;
      pulse_cnt_r <= pulse_cnt_next_s;
      start_r     <= (state_next_s == RUN);
      ready_r     <= (state_next_s == READY);
      busy_r      <= (state_next_s == LOAD_REQ) || (state_next_s == LOAD_REL) ||
                     (state_next_s == RUN) || (state_next_s == GAP);
      done_r      <= done_s;
      cfg_rej_r   <= reject_cfg_s;
    end
  end

  assign bus.REQ            = req_s;
  assign bus.DDS_freq       = dds_freq_r;
  assign bus.DDS_delta_freq = dds_delta_freq_r;
  assign bus.DDS_delta_rate = dds_delta_rate_r;
  assign bus.start          = start_r;

  assign ready     = ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign cfg_rej   = cfg_rej_r;
  assign pulse_cnt = pulse_cnt_r;

endmodule

// File: tb/tb_chirp_sequencer.sv
// Directed bench for chirp_sequencer: a table of burst configurations plus
// hand-written sequences for abort, rejects, priority and reset corners.
// ACK is modelled as REQ delayed by four clk_48 cycles.
module tb_chirp_sequencer;
  import chirp_pkg::*;

  logic        clk_48 = 1'b0;
  logic        rst;
  logic        cfg_wr;
  logic [47:0] cfg_freq;
  logic [47:0] cfg_delta_freq;
  logic [31:0] cfg_delta_rate;
  logic [31:0] cfg_len;
  logic [31:0] cfg_gap;
  logic [15:0] cfg_count;
  logic        arm;
  logic        abort;
  logic        ready;
  logic        busy;
  logic        done;
  logic        cfg_rej;
  logic [15:0] pulse_cnt;

  logic        ack_en;
  logic [3:0]  ack_sh = 4'd0;

  int total = 0;
  int bad   = 0;

  chirp_sequencer_if bus();

  chirp_sequencer dut (
    .clk_48         (clk_48),
    .rst            (rst),
    .cfg_wr         (cfg_wr),
    .cfg_freq       (cfg_freq),
    .cfg_delta_freq (cfg_delta_freq),
    .cfg_delta_rate (cfg_delta_rate),
    .cfg_len        (cfg_len),
    .cfg_gap        (cfg_gap),
    .cfg_count      (cfg_count),
    .arm            (arm),
    .abort          (abort),
    .bus            (bus),
    .ready          (ready),
    .busy           (busy),
    .done           (done),
    .cfg_rej        (cfg_rej),
    .pulse_cnt      (pulse_cnt)
  );

  always #10 clk_48 = ~clk_48;

  // ACK model: REQ delayed by four cycles, gated so the bench can stall it.
  always @(posedge clk_48) ack_sh <= {ack_sh[2:0], bus.REQ};
  assign bus.ACK = ack_en & ack_sh[3];

  typedef struct {
    logic [47:0] freq;
    logic [31:0] len;
    logic [31:0] gap;
    logic [15:0] count;
    int          exp_high;
    int          exp_rises;
    int          exp_done_at;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_48);
    #1;
  endtask

  task automatic load_begin(input logic [47:0] f, input logic [31:0] len,
                            input logic [31:0] gap, input logic [15:0] cnt);
    cfg_freq       = f;
    cfg_delta_freq = {f[23:0], f[47:24]};
    cfg_delta_rate = f[31:0] ^ 32'h5a5a_0001;
    cfg_len        = len;
    cfg_gap        = gap;
    cfg_count      = cnt;
    cfg_wr         = 1'b1;
    step();
    cfg_wr         = 1'b0;
  endtask

  task automatic wait_ready(output int rdy_at);
    rdy_at = -1;
    for (int i = 1; i <= 40 && rdy_at < 0; i++) begin
      step();
      if (ready) rdy_at = i;
    end
  endtask

  // Full load with the 4-cycle ACK model and timing checks.
  task automatic load(input logic [47:0] f, input logic [31:0] len,
                      input logic [31:0] gap, input logic [15:0] cnt);
    int req_fall;
    int rdy_at;
    load_begin(f, len, gap, cnt);
    chk("load_req_rise", 64'(bus.REQ), 64'(1));
    chk("load_dds_freq", 64'(bus.DDS_freq), 64'(f));
    chk("load_dds_dfreq", 64'(bus.DDS_delta_freq), 64'({f[23:0], f[47:24]}));
    chk("load_dds_rate", 64'(bus.DDS_delta_rate), 64'(f[31:0] ^ 32'h5a5a_0001));
    chk("load_ready_low", 64'(ready), 64'(0));
    chk("load_busy", 64'(busy), 64'(1));
    req_fall = -1;
    rdy_at   = -1;
    for (int i = 1; i <= 40 && rdy_at < 0; i++) begin
      step();
      if (req_fall < 0 && !bus.REQ) req_fall = i;
      if (ready) rdy_at = i;
    end
    chk("load_req_fall_at", 64'(req_fall), 64'(5));
    chk("load_ready_at", 64'(rdy_at), 64'(10));
  endtask

  initial begin
    int high, rises, done_at, done_cnt, rdy_at;
    logic prev;

    vecs[0] = '{48'h0000_1000_0000, 32'd5, 32'd3, 16'd3, 15, 3, 22};
    vecs[1] = '{48'h0000_0000_0abc, 32'd0, 32'd0, 16'd2, 2, 2, 5};
    vecs[2] = '{48'h1234_5678_9abc, 32'd1, 32'd1, 16'd1, 1, 1, 2};
    vecs[3] = '{48'h0fed_cba9_8765, 32'd3, 32'd2, 16'd4, 12, 4, 19};
    vecs[4] = '{48'h8000_0000_0001, 32'd2, 32'd5, 16'd2, 4, 2, 10};
    vecs[5] = '{48'h0000_0001_0000, 32'd1, 32'd1, 16'd3, 3, 3, 8};

    rst = 1'b1; cfg_wr = 1'b0; arm = 1'b0; abort = 1'b0; ack_en = 1'b1;
    cfg_freq = 48'd0; cfg_delta_freq = 48'd0; cfg_delta_rate = 32'd0;
    cfg_len = 32'd0; cfg_gap = 32'd0; cfg_count = 16'd0;
    repeat (3) step();
    rst = 1'b0;

    // Reset state.
    chk("rst_req", 64'(bus.REQ), 64'(0));
    chk("rst_start", 64'(bus.start), 64'(0));
    chk("rst_ready", 64'(ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_cfg_rej", 64'(cfg_rej), 64'(0));
    chk("rst_dds_freq", 64'(bus.DDS_freq), 64'(0));
    chk("rst_pulse_cnt", 64'(pulse_cnt), 64'(0));

    // arm with nothing loaded is ignored.
    arm = 1'b1; step(); arm = 1'b0;
    chk("idle_arm_start", 64'(bus.start), 64'(0));
    chk("idle_arm_busy", 64'(busy), 64'(0));

    // Table of bursts.
    for (int v = 0; v < 6; v++) begin
      load(vecs[v].freq, vecs[v].len, vecs[v].gap, vecs[v].count);
      high = 0; rises = 0; done_at = -1; done_cnt = 0; prev = 1'b0;
      arm = 1'b1; step(); arm = 1'b0;
      for (int off = 1; off <= 300 && !(done_at >= 0 && off > done_at + 3); off++) begin
        if (bus.start) high++;
        if (bus.start && !prev) rises++;
        prev = bus.start;
        if (done) begin
          done_cnt++;
          if (done_at < 0) begin
            done_at = off;
            chk("vec_ready_at_done", 64'(ready), 64'(1));
          end
        end
        step();
      end
      chk("vec_high_cycles", 64'(high), 64'(vecs[v].exp_high));
      chk("vec_rises", 64'(rises), 64'(vecs[v].exp_rises));
      chk("vec_done_at", 64'(done_at), 64'(vecs[v].exp_done_at));
      chk("vec_done_once", 64'(done_cnt), 64'(1));
      chk("vec_pulse_cnt", 64'(pulse_cnt), 64'(vecs[v].count));
      chk("vec_dds_hold", 64'(bus.DDS_freq), 64'(vecs[v].freq));
    end

    // Abort during the 4th high cycle of the 7th pulse of a continuous burst.
    load(48'h0000_2000_0000, 32'd10, 32'd3, 16'd0);
    arm = 1'b1; step(); arm = 1'b0;
    rises = 1; done_cnt = 0; prev = bus.start;
    repeat (81) begin
      step();
      if (bus.start && !prev) rises++;
      if (done) done_cnt++;
      prev = bus.start;
    end
    chk("abort_pre_start", 64'(bus.start), 64'(1));
    chk("abort_pre_rises", 64'(rises), 64'(7));
    chk("abort_pre_cnt", 64'(pulse_cnt), 64'(6));
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_start", 64'(bus.start), 64'(0));
    chk("abort_ready", 64'(ready), 64'(1));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done | (done_cnt != 0)), 64'(0));
    step();
    chk("abort_cnt_hold", 64'(pulse_cnt), 64'(6));
    chk("abort_no_done", 64'(done), 64'(0));

    // cfg_wr during RUN is rejected; burst carries on.
    load(48'h0000_3000_0000, 32'd20, 32'd3, 16'd1);
    arm = 1'b1; step(); arm = 1'b0;
    repeat (3) step();
    cfg_freq = 48'h0000_dead_beef; cfg_wr = 1'b1; step(); cfg_wr = 1'b0;
    chk("rej_run_pulse", 64'(cfg_rej), 64'(1));
    chk("rej_run_dds", 64'(bus.DDS_freq), 64'(48'h0000_3000_0000));
    chk("rej_run_start", 64'(bus.start), 64'(1));
    done_at = -1;
    for (int off = 6; off <= 60 && done_at < 0; off++) begin
      step();
      if (off == 6) chk("rej_run_pulse_end", 64'(cfg_rej), 64'(0));
      if (done) done_at = off;
    end
    chk("rej_run_done_at", 64'(done_at), 64'(21));
    chk("rej_run_cnt", 64'(pulse_cnt), 64'(1));

    // cfg_wr during LOAD_REQ is rejected; handshake completes with first set.
    ack_en = 1'b0;
    load_begin(48'h0000_4000_0000, 32'd2, 32'd2, 16'd1);
    chk("rej_load_req", 64'(bus.REQ), 64'(1));
    cfg_freq = 48'h0000_5555_5555; cfg_wr = 1'b1; step(); cfg_wr = 1'b0;
    chk("rej_load_pulse", 64'(cfg_rej), 64'(1));
    chk("rej_load_req_hold", 64'(bus.REQ), 64'(1));
    chk("rej_load_dds", 64'(bus.DDS_freq), 64'(48'h0000_4000_0000));
    step();
    chk("rej_load_pulse_end", 64'(cfg_rej), 64'(0));
    ack_en = 1'b1;
    wait_ready(rdy_at);
    chk("rej_load_ready", 64'(rdy_at > 0), 64'(1));
    chk("rej_load_dds_final", 64'(bus.DDS_freq), 64'(48'h0000_4000_0000));

    // cfg_wr and arm together in READY: the load wins.
    cfg_freq = 48'h0000_6000_0000; cfg_wr = 1'b1; arm = 1'b1; step();
    cfg_wr = 1'b0; arm = 1'b0;
    chk("prio_cfg_req", 64'(bus.REQ), 64'(1));
    chk("prio_cfg_start", 64'(bus.start), 64'(0));
    chk("prio_cfg_dds", 64'(bus.DDS_freq), 64'(48'h0000_6000_0000));
    wait_ready(rdy_at);
    chk("prio_cfg_ready", 64'(rdy_at), 64'(10));

    // arm and abort together in READY: arm wins.
    arm = 1'b1; abort = 1'b1; step(); arm = 1'b0; abort = 1'b0;
    chk("prio_arm_start", 64'(bus.start), 64'(1));
    abort = 1'b1; step(); abort = 1'b0;
    chk("prio_abort_start", 64'(bus.start), 64'(0));

    // Reset while start is high.
    load(48'h0000_7000_0000, 32'd8, 32'd2, 16'd0);
    arm = 1'b1; step(); arm = 1'b0;
    step();
    chk("rst_run_pre", 64'(bus.start), 64'(1));
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_run_start", 64'(bus.start), 64'(0));
    chk("rst_run_ready", 64'(ready), 64'(0));
    chk("rst_run_cnt", 64'(pulse_cnt), 64'(0));
    chk("rst_run_dds", 64'(bus.DDS_freq), 64'(0));
    arm = 1'b1; step(); arm = 1'b0;
    chk("rst_run_arm_ign", 64'(bus.start), 64'(0));

    // Reset while REQ is high.
    ack_en = 1'b0;
    load_begin(48'h0000_8000_0000, 32'd2, 32'd2, 16'd1);
    chk("rst_hs_pre", 64'(bus.REQ), 64'(1));
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_hs_req", 64'(bus.REQ), 64'(0));
    chk("rst_hs_busy", 64'(busy), 64'(0));
    repeat (6) step();
    ack_en = 1'b1;
    arm = 1'b1; step(); arm = 1'b0;
    chk("rst_hs_arm_ign", 64'(bus.start), 64'(0));
    chk("rst_hs_ready", 64'(ready), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
